rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters.
- Produces a one-hot grant plus its 3-bit binary index, using the same encoding as the 8-to-3 encoder datapath: index = position of the single set grant bit.
- Grants are held while the requester keeps its request asserted.
- A hold counter forces rotation under contention, so no requester starves.
- Sits between the request sources and the shared resource's select/mux logic.

---
 rtl/rr_arbiter_8.sv | 118 +++++++++++
 tb/tb_rr_arbiter_8.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter that shares one resource among 8 requesters, with a registered one-hot grant and index.
// A hold counter forces rotation under contention, so a holder cannot keep the resource forever while others wait.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [7:0]       others;
  logic             at_max;

  // First set bit of vec, searching from start upward and wrapping mod 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] vec, input logic [2:0] start);
    logic [2:0] pick;
    logic [2:0] pos;
    pick = start;
    for (int k = 7; k >= 0; k--) begin
      pos = start + 3'(k);
      if (vec[pos]) pick = pos;
    end
    return pick;
  endfunction

  assign others = req & ~gnt_q;
  assign at_max = (hold_q == CNT_W'(MAX_HOLD));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;

    case (state_q)
      IDLE: begin
        if (en && (req != 8'h00)) begin
          idx_d   = rr_pick(req, ptr_q);
          valid_d = 1'b1;
          hold_d  = CNT_W'(1);
          state_d = GRANT;
        end else begin
          idx_d   = 3'd0;
          valid_d = 1'b0;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          ptr_d = idx_q + 3'd1;
          if (en && (others != 8'h00)) begin
            idx_d  = rr_pick(others, idx_q + 3'd1);
            hold_d = CNT_W'(1);
          end else begin
            idx_d   = 3'd0;
            valid_d = 1'b0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if (at_max && en && (others != 8'h00)) begin
          // Holder has used its full share while someone else waits: rotate.
          ptr_d  = idx_q + 3'd1;
          idx_d  = rr_pick(others, idx_q + 3'd1);
          hold_d = CNT_W'(1);
        end else if (!at_max) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        idx_d   = 3'd0;
        valid_d = 1'b0;
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase

    gnt_d = valid_d ? (8'h01 << idx_d) : 8'h00;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 8'h00;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: directed steps push the expected post-edge outputs; a monitor pops and compares.
module tb_rr_arbiter_8;

  localparam int unsigned MAX_HOLD = 4;

  typedef struct {
    int         id;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;
  int   step_id;
  logic mon_en;

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h ({gnt,idx,valid})", name, act, exp);
    end
  endtask

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // Drive inputs for one cycle and queue the outputs expected right after the next rising edge.
  task automatic step(input logic r, input logic e, input logic [7:0] rq,
                      input logic v, input logic [2:0] ix);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    req = rq;
    step_id++;
    x.id    = step_id;
    x.valid = v;
    x.idx   = v ? ix : 3'd0;
    x.gnt   = v ? (8'h01 << ix) : 8'h00;
    exp_q.push_back(x);
    mon_en = 1'b1;
  endtask

  // Monitor: after every rising edge, check invariants and pop one expectation if queued.
  initial begin
    exp_t  e;
    logic  inv_ok;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        inv_ok = $onehot0(gnt) && (gnt_valid == (gnt != 8'h00)) && (gnt_idx == encode(gnt));
        check("invariant", {11'd0, inv_ok}, 12'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("step%0d", e.id), {gnt, gnt_idx, gnt_valid}, {e.gnt, e.idx, e.valid});
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    step_id  = 0;
    mon_en   = 1'b0;
    rst = 1'b1;
    en  = 1'b1;
    req = 8'hFF;

    // Reset held with all requests pending, then first grant goes to index 0.
    step(1'b1, 1'b1, 8'hFF, 1'b0, 3'd0);
    step(1'b1, 1'b1, 8'hFF, 1'b0, 3'd0);
    step(1'b0, 1'b1, 8'hFF, 1'b1, 3'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 3'd0);   // ptr -> 1

    // Lone requester 5, then drop.
    step(1'b0, 1'b1, 8'h20, 1'b1, 3'd5);
    step(1'b0, 1'b1, 8'h20, 1'b1, 3'd5);
    step(1'b0, 1'b1, 8'h00, 1'b0, 3'd0);

    // Back-to-back rotation 0..7,0 from a fresh pointer.
    step(1'b1, 1'b1, 8'h00, 1'b0, 3'd0);
    step(1'b0, 1'b1, 8'hFF, 1'b1, 3'd0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 8'hFF, 1'b1, 3'(k));
      step(1'b0, 1'b1, ~(8'h01 << k), 1'b1, 3'((k + 1) % 8));
    end
    step(1'b0, 1'b1, 8'h00, 1'b0, 3'd0);

    // Contention between 0 and 7: each holds exactly MAX_HOLD cycles.
    step(1'b1, 1'b1, 8'h00, 1'b0, 3'd0);
    for (int round = 0; round < 3; round++)
      for (int c = 0; c < int'(MAX_HOLD); c++)
        step(1'b0, 1'b1, 8'h81, 1'b1, (round == 1) ? 3'd7 : 3'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 3'd0);   // ptr -> 1

    // Wrap: 6 releases with only 0 pending, search from 7 lands on 0.
    step(1'b0, 1'b1, 8'h40, 1'b1, 3'd6);
    step(1'b0, 1'b1, 8'h41, 1'b1, 3'd6);
    step(1'b0, 1'b1, 8'h01, 1'b1, 3'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 3'd0);   // ptr -> 1

    // en=0 blocks new grants but never revokes or preempts an existing one.
    step(1'b0, 1'b0, 8'h08, 1'b0, 3'd0);
    step(1'b0, 1'b0, 8'h08, 1'b0, 3'd0);
    step(1'b0, 1'b1, 8'h08, 1'b1, 3'd3);
    for (int c = 0; c < int'(MAX_HOLD) + 2; c++)
      step(1'b0, 1'b0, 8'h0C, 1'b1, 3'd3);
    step(1'b0, 1'b0, 8'h04, 1'b0, 3'd0);   // ptr -> 4, no grant to 2
    step(1'b0, 1'b0, 8'h04, 1'b0, 3'd0);

    // Reset asserted mid-grant drops the grant at that edge.
    step(1'b0, 1'b1, 8'h04, 1'b1, 3'd2);
    step(1'b1, 1'b1, 8'h04, 1'b0, 3'd0);
    step(1'b0, 1'b1, 8'h04, 1'b1, 3'd2);
    step(1'b0, 1'b1, 8'h00, 1'b0, 3'd0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
